// File: rtl/game_pkg.sv
// game_pkg: shared FSM state type, screen geometry and colour constants for the sprite path
package game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLOT = 2'd1, DONE = 2'd2} state_t;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int MAX_DIM_DEFAULT = 16;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// sprite_draw_scheduler_if: requester bus (req/rect/colour in, ack/done out) plus VGA pixel port
//   master: requesters + VGA sink side; slave: the scheduler
interface sprite_draw_scheduler_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ*7-1:0] req_y;
  logic [NUM_REQ*5-1:0] req_w;
  logic [NUM_REQ*5-1:0] req_h;
  logic [NUM_REQ*3-1:0] req_colour;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;
  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  ack, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output ack, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: raster col/row walker over a w x h rectangle with 9-bit screen clip test
//   i_start clears the walk, i_en advances one pixel (col inner, row outer)
//   o_col/o_row current offsets, o_last on the final pixel, o_in_range when (x+col, y+row) is on screen
module rect_scanner
  import game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_en,
  input  logic [7:0] i_x,
  input  logic [6:0] i_y,
  input  logic [4:0] i_w,
  input  logic [4:0] i_h,
  output logic [4:0] o_col,
  output logic [4:0] o_row,
  output logic       o_last,
  output logic       o_in_range
);
  logic [4:0] r_col, r_row;
  logic       w_col_end;
  logic [8:0] w_px, w_py;
  always_comb begin
    w_col_end  = r_col == i_w - 5'd1;
    w_px       = 9'(i_x) + 9'(r_col);
    w_py       = 9'(i_y) + 9'(r_row);
    o_col      = r_col;
    o_row      = r_row;
    o_last     = w_col_end && r_row == i_h - 5'd1;
    o_in_range = w_px < 9'(SCREEN_W) && w_py < 9'(SCREEN_H);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      r_col <= w_col_end ? 5'd0 : r_col + 5'd1;
      r_row <= w_col_end ? r_row + 5'd1 : r_row;
    end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: fixed-priority, non-preemptive rectangle fill scheduler driving a VGA plot port
//   CLOCK_50 clock, resetn async active-low reset
//   bus.req/req_* per-requester jobs; bus.ack grant pulse, bus.done completion pulse, bus.busy
//   bus.vga_x/vga_y/vga_colour/vga_plot one pixel per PLOT cycle, clipped pixels keep their cycle
module sprite_draw_scheduler
  import game_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_DIM = MAX_DIM_DEFAULT
) (
  input logic                  CLOCK_50,
  input logic                  resetn,
  sprite_draw_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PLOT = PLOT;
  localparam logic [1:0] S_DONE = DONE;
  localparam logic [4:0] DIM_SAT = MAX_DIM > 31 ? 5'd31 : 5'(MAX_DIM);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic [4:0]         r_w, r_h;
  logic [2:0]         r_colour;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_grant, w_plot, w_last, w_in_range;
  logic [4:0]         w_w_raw, w_h_raw, w_w, w_h, w_col, w_row;
  always_comb begin
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.req[i]) w_idx = IW'(i);
    // isolate the lowest set request bit: index 0 wins
    w_gnt          = bus.req & (~bus.req + NUM_REQ'(1));
    w_grant        = r_state == S_IDLE && |bus.req;
    w_w_raw        = bus.req_w[w_idx*5 +: 5];
    w_h_raw        = bus.req_h[w_idx*5 +: 5];
    w_w            = w_w_raw > DIM_SAT ? DIM_SAT : w_w_raw;
    w_h            = w_h_raw > DIM_SAT ? DIM_SAT : w_h_raw;
    w_plot         = r_state == S_PLOT && w_in_range;
    // ack is combinational on req, so gate it so reset silences every output at once
    bus.ack        = resetn && w_grant ? w_gnt : '0;
    bus.done       = r_state == S_DONE ? r_gnt : '0;
    bus.busy       = r_state != S_IDLE;
    bus.vga_plot   = w_plot;
    bus.vga_x      = r_state == S_PLOT ? r_x + 8'(w_col) : 8'd0;
    bus.vga_y      = r_state == S_PLOT ? r_y + 7'(w_row) : 7'd0;
    bus.vga_colour = w_plot ? r_colour : 3'd0;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_colour <= '0;
    end else if (w_grant) begin
      r_state  <= w_w == 5'd0 || w_h == 5'd0 ? S_DONE : S_PLOT;
      r_gnt    <= w_gnt;
      r_x      <= bus.req_x[w_idx*8 +: 8];
      r_y      <= bus.req_y[w_idx*7 +: 7];
      r_w      <= w_w;
      r_h      <= w_h;
      r_colour <= bus.req_colour[w_idx*3 +: 3];
    end else if (r_state == S_PLOT) begin
      r_state <= w_last ? S_DONE : S_PLOT;
    end else begin
      r_state <= S_IDLE;
    end
  rect_scanner u_scan (
    .i_clk      (CLOCK_50),
    .i_rst_n    (resetn),
    .i_start    (w_grant),
    .i_en       (r_state == S_PLOT),
    .i_x        (r_x),
    .i_y        (r_y),
    .i_w        (r_w),
    .i_h        (r_h),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last     (w_last),
    .o_in_range (w_in_range)
  );
endmodule

// File: doc/sprite_draw_scheduler.md
SPRITE_DRAW_SCHEDULER -- requirements
Module: sprite_draw_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 3: number of rectangle requesters; index 0 has highest priority.
REQ-002 Parameter MAX_DIM, default 16: maximum rectangle width/height in pixels.
REQ-003 CLOCK_50  in  1  single clock; one clock; all state on its rising edge.
REQ-004 resetn  in  1  reset is asynchronous and active-low.
REQ-005 req  in  NUM_REQ  per-requester level request; held until the matching done.
REQ-006 req_x  in  NUM_REQ*8  per-requester rectangle top-left x, 0..255.
REQ-007 req_y  in  NUM_REQ*7  per-requester rectangle top-left y, 0..127.
REQ-008 req_w  in  NUM_REQ*5  per-requester width, 0..31.
REQ-009 req_h  in  NUM_REQ*5  per-requester height, 0..31.
REQ-010 req_colour  in  NUM_REQ*3  per-requester fill colour (RGB, 1 bit each).
REQ-011 ack  out  NUM_REQ  one-hot, one-cycle pulse on grant.
REQ-012 done  out  NUM_REQ  one-hot, one-cycle pulse at job completion.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 vga_x  out  8  pixel x to the VGA adapter.
REQ-015 vga_y  out  7  pixel y to the VGA adapter.
REQ-016 vga_colour  out  3  pixel colour to the VGA adapter.
REQ-017 vga_plot  out  1  write strobe to the VGA adapter.

Function
REQ-018 FSM states: IDLE, PLOT, DONE; no other reachable states.
REQ-019 In IDLE with any req high, the lowest-index requester with req high is granted.
REQ-020 The grant cycle:
- pulses that requester's ack;
- latches x, y, colour, and w, h saturated to MAX_DIM;
- moves to PLOT.
REQ-021 If the latched w or h is 0, the grant moves directly to DONE and no pixel is plotted.
REQ-022 PLOT emits exactly w*h pixel cycles in raster order, column index inner, row index outer.
REQ-023 The first pixel is (x,y), on the cycle after ack.
REQ-024 Each pixel cycle drives vga_x = x+col and vga_y = y+row.
REQ-025 Pixel coordinates are computed at 9-bit width; vga_x/vga_y carry the low 8/7 bits.
REQ-026 A pixel with 9-bit x >= 160 or y >= 120 still occupies its cycle but drives vga_plot=0.
REQ-027 An in-range pixel drives vga_plot=1 with vga_colour = the latched colour.
REQ-028 After the last pixel cycle the FSM enters DONE for exactly one cycle.
REQ-029 In DONE, done is pulsed for the granted requester, then the FSM returns to IDLE.
REQ-030 Latency: ack at cycle N, pixels N+1..N+w*h, done at N+w*h+1, earliest next ack at N+w*h+2.
REQ-031 Arbitration is non-preemptive: req changes and higher-priority requests during PLOT/DONE are ignored until IDLE.
REQ-032 A requester still holding req in IDLE after its done is treated as a new job.
REQ-033 Request inputs are sampled only in the grant cycle; later changes to them do not alter the running job.
REQ-034 Outside PLOT: vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-035 ack and done are never high in the same cycle and are always one-hot or zero.

Reset
REQ-036 Asserting resetn low immediately forces:
- state IDLE;
- all outputs 0;
- latched job and counters cleared.
REQ-037 A job interrupted by reset produces no done; its requester must re-request after reset.
REQ-038 The first grant can occur on the first rising edge after resetn deasserts.

Structure
REQ-039 Shared package game_pkg holds:
- the FSM state enum;
- SCREEN_W=160 and SCREEN_H=120;
- the MAX_DIM default;
- colour constants BLACK=3'b000 and GREEN=3'b010.
REQ-040 Raster col/row counting and the clip compare live in one sub-module, rect_scanner (start, w, h in; col, row, last, in_range out).
REQ-041 Priority selection is combinational inside sprite_draw_scheduler; there is no other sub-module.

Verification
REQ-042 Single job: req[1] with x=80, y=50, w=4, h=4, colour=010.
- ack[1] pulses at cycle N.
- 16 plotted pixels (80,50)..(83,53), row-major, N+1..N+16.
- done[1] pulses at N+17.
REQ-043 Priority: req[0] (x=0, y=0, 2x1) and req[2] (x=10, y=10, 1x1) both rise in the same IDLE cycle.
- Requester 0 is served first.
- ack[2] follows done[0] by exactly 1 cycle.
REQ-044 Clipping: x=158, y=118, w=4, h=4.
- 16 pixel cycles occur.
- vga_plot=1 only for the 4 pixels (158..159, 118..119).
- done arrives on schedule.
REQ-045 Zero/saturate:
- w=0, h=5 gives ack at N, done at N+1, no vga_plot.
- w=31, h=1 gives exactly 16 pixel cycles.
REQ-046 Reset mid-job: resetn low at the 5th pixel of a 4x4 job.
- Outputs drop to 0 immediately; no done is pulsed.
- After resetn high with req still held, a fresh ack is pulsed and all 16 pixels plot from the start.
